// File: rtl/dmem_responder.sv
//==============================================================================
// Module  : dmem_responder
// Brief   : Word-organised data-memory target with programmable access
//           latency and misaligned / out-of-range error reporting.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_responder #(
  parameter int AW      = 6,
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [7:0]  err_count
);

  localparam int         c_depth    = 2 ** AW;
  localparam logic [3:0] c_lat_init = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_lat_cnt;
  logic [3:0]  w_lat_cnt_nxt;

  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic [7:0]  r_err_count;

  logic [31:0] r_mem [0:c_depth-1];

  logic          w_accept;
  logic          w_commit;
  logic          w_resp_done;
  logic [AW-1:0] w_word_idx;
  logic          w_misaligned;
  logic          w_out_of_range;
  logic          w_err;
  logic          w_mem_we;

  // Decode works on the captured request so later bus changes cannot disturb it
  assign w_word_idx     = r_addr[AW+1:2];
  assign w_misaligned   = |r_addr[1:0];
  assign w_out_of_range = |r_addr[31:AW+2];
  assign w_err          = w_misaligned | w_out_of_range;

  assign w_accept    = (r_state == ST_IDLE) && req_valid;
  assign w_commit    = (r_state == ST_BUSY) && (r_lat_cnt == 4'd0);
  assign w_resp_done = (r_state == ST_RESP) && resp_ready;
  assign w_mem_we    = Reset_L && w_commit && r_write && !w_err;

  always_comb begin
    w_state_nxt   = r_state;
    w_lat_cnt_nxt = r_lat_cnt;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_state_nxt   = ST_BUSY;
          w_lat_cnt_nxt = c_lat_init;
        end
      end
      ST_BUSY: begin
        if (r_lat_cnt != 4'd0) begin
          w_lat_cnt_nxt = r_lat_cnt - 4'd1;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_lat_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      r_state   <= ST_IDLE;
      r_lat_cnt <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_cnt_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset_L && w_accept) begin
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // Response registers hold steady for the whole RESP phase
  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
      r_err_count  <= 8'd0;
    end else if (w_commit) begin
      r_resp_valid <= 1'b1;
      r_resp_err   <= w_err;
      if (w_err || r_write) begin
        r_resp_rdata <= 32'd0;
      end else begin
        r_resp_rdata <= r_mem[w_word_idx];
      end
      if (w_err && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end else if (w_resp_done) begin
      r_resp_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      r_mem[w_word_idx] <= r_wdata;
    end
  end

  assign req_ready  = Reset_L && (r_state == ST_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign err_count  = r_err_count;

endmodule

`default_nettype wire
